// File: rtl/decode_issue_buffer_pkg.sv
// Shared types for the decode-to-execute issue buffer.
// Entry layout and shadow FSM states.
package decode_issue_buffer_pkg;

  localparam int DEF_RD_ID_W = 6;
  localparam int DEF_RS_ID_W = 5;

  typedef struct packed {
    logic [DEF_RD_ID_W-1:0] rd;
    logic [DEF_RS_ID_W-1:0] rs1;
    logic [DEF_RS_ID_W-1:0] rs2;
    logic                   resolve;
    logic                   select_target_pc;
    logic                   squash_j;
    logic                   squash_jalr;
  } decode_entry_t;

  typedef enum logic {
    PASS   = 1'b0,
    SHADOW = 1'b1
  } shadow_state_e;

endpackage

// File: rtl/decode_issue_buffer_fifo_core.sv
// Circular entry store with head-only retention
// for branch redirects and a full clear.
module issue_fifo_core #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   clear_younger,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clear) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      // keep only the head, then apply push/pop on top
      if (clear_younger) begin
        wptr_d  = rptr_q + 1'b1;
        count_d = CW'(1);
      end
      if (push) begin
        mem_d[wptr_d] = wdata;
        wptr_d        = wptr_d + 1'b1;
        count_d       = count_d + 1'b1;
      end
      if (pop) begin
        rptr_d  = rptr_q + 1'b1;
        count_d = count_d - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/decode_issue_buffer.sv
// Decode-to-execute issue buffer: jump-shadow discard,
// branch redirect flush and saturating drop accounting.
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int RD_ID_W     = DEF_RD_ID_W,
  parameter int RS_ID_W     = DEF_RS_ID_W,
  parameter int DEPTH       = 4,
  parameter int SHADOW_J    = 1,
  parameter int SHADOW_JALR = 2,
  parameter int DROP_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RD_ID_W-1:0]     in_reg_rd_id,
  input  logic [RS_ID_W-1:0]     in_rs1_id,
  input  logic [RS_ID_W-1:0]     in_rs2_id,
  input  logic                   in_resolve,
  input  logic                   in_select_target_pc,
  input  logic                   in_squash_after_J,
  input  logic                   in_squash_after_JALR,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RD_ID_W-1:0]     out_reg_rd_id,
  output logic [RS_ID_W-1:0]     out_rs1_id,
  output logic [RS_ID_W-1:0]     out_rs2_id,
  output logic                   out_resolve,
  output logic                   out_select_target_pc,
  output logic                   out_squash_after_J,
  output logic                   out_squash_after_JALR,
  output logic [$clog2(DEPTH):0] count,
  output logic                   shadow_active,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int INC_W = CNT_W + 1;
  localparam int SUM_W = DROP_W + 1;
  localparam int ENT_W = RD_ID_W + 2 * RS_ID_W + 4;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  shadow_state_e     state_q, state_d;
  logic [2:0]        rem_q, rem_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [INC_W-1:0]  inc;
  logic [SUM_W-1:0]  sum;
  logic              accept, pop, redirect, push;
  logic [ENT_W-1:0]  wdata, rdata;

  assign in_ready  = (count < FULL) && !flush;
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign redirect  = pop && out_resolve
                   && out_select_target_pc && !flush;

  assign wdata = {in_reg_rd_id, in_rs1_id, in_rs2_id,
                  in_resolve, in_select_target_pc,
                  in_squash_after_J, in_squash_after_JALR};

  assign {out_reg_rd_id, out_rs1_id, out_rs2_id,
          out_resolve, out_select_target_pc,
          out_squash_after_J, out_squash_after_JALR} = rdata;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    push    = 1'b0;
    inc     = '0;
    if (flush) begin
      state_d = PASS;
      rem_d   = '0;
    end else if (redirect) begin
      // entries behind the head plus the same-cycle accept
      state_d = PASS;
      rem_d   = '0;
      inc     = {1'b0, count} - 1'b1
              + {{CNT_W{1'b0}}, accept};
    end else if (accept) begin
      unique case (state_q)
        PASS: begin
          push = 1'b1;
          if (in_squash_after_JALR && SHADOW_JALR > 0) begin
            state_d = SHADOW;
            rem_d   = 3'(SHADOW_JALR);
          end else if (in_squash_after_J && SHADOW_J > 0) begin
            state_d = SHADOW;
            rem_d   = 3'(SHADOW_J);
          end
        end
        SHADOW: begin
          inc   = INC_W'(1);
          rem_d = rem_q - 1'b1;
          if (rem_q == 3'd1) begin
            state_d = PASS;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sum    = {1'b0, drop_q} + SUM_W'(inc);
    drop_d = sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PASS;
      rem_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
    end
  end

  issue_fifo_core #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (flush),
    .clear_younger (redirect),
    .push          (push),
    .pop           (pop),
    .wdata         (wdata),
    .rdata         (rdata),
    .count         (count)
  );

  assign shadow_active = (state_q == SHADOW);
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Bench for decode_issue_buffer: queue model, directed
// scenarios and random traffic on two drop-counter widths.
module tb_decode_issue_buffer;
  import decode_issue_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int SJ    = 1;
  localparam int SJALR = 2;

  logic clk;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic [5:0] in_rd;
  logic [4:0] in_rs1, in_rs2;
  logic in_res, in_sel, in_j, in_jalr;
  logic out_ready;

  logic o0_in_ready, o0_out_valid;
  logic [5:0] o0_rd;
  logic [4:0] o0_rs1, o0_rs2;
  logic o0_res, o0_sel, o0_j, o0_jalr;
  logic [2:0] o0_count;
  logic o0_shadow;
  logic [15:0] o0_drop;

  logic o1_in_ready, o1_out_valid;
  logic [5:0] o1_rd;
  logic [4:0] o1_rs1, o1_rs2;
  logic o1_res, o1_sel, o1_j, o1_jalr;
  logic [2:0] o1_count;
  logic o1_shadow;
  logic [1:0] o1_drop;

  int total = 0;
  int bad = 0;

  decode_entry_t q[$];
  int shadow_left = 0;
  int drops = 0;

  decode_issue_buffer u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o0_in_ready),
    .in_reg_rd_id(in_rd), .in_rs1_id(in_rs1),
    .in_rs2_id(in_rs2), .in_resolve(in_res),
    .in_select_target_pc(in_sel),
    .in_squash_after_J(in_j),
    .in_squash_after_JALR(in_jalr),
    .out_valid(o0_out_valid), .out_ready(out_ready),
    .out_reg_rd_id(o0_rd), .out_rs1_id(o0_rs1),
    .out_rs2_id(o0_rs2), .out_resolve(o0_res),
    .out_select_target_pc(o0_sel),
    .out_squash_after_J(o0_j),
    .out_squash_after_JALR(o0_jalr),
    .count(o0_count), .shadow_active(o0_shadow),
    .drop_count(o0_drop)
  );

  decode_issue_buffer #(.DROP_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_reg_rd_id(in_rd), .in_rs1_id(in_rs1),
    .in_rs2_id(in_rs2), .in_resolve(in_res),
    .in_select_target_pc(in_sel),
    .in_squash_after_J(in_j),
    .in_squash_after_JALR(in_jalr),
    .out_valid(o1_out_valid), .out_ready(out_ready),
    .out_reg_rd_id(o1_rd), .out_rs1_id(o1_rs1),
    .out_rs2_id(o1_rs2), .out_resolve(o1_res),
    .out_select_target_pc(o1_sel),
    .out_squash_after_J(o1_j),
    .out_squash_after_JALR(o1_jalr),
    .count(o1_count), .shadow_active(o1_shadow),
    .drop_count(o1_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic decode_entry_t mk(input int rd);
    decode_entry_t e;
    e = '0;
    e.rd  = 6'(rd);
    e.rs1 = 5'(rd + 1);
    e.rs2 = 5'(rd + 2);
    return e;
  endfunction

  function automatic decode_entry_t rnd_entry();
    decode_entry_t e;
    e.rd  = 6'($urandom);
    e.rs1 = 5'($urandom);
    e.rs2 = 5'($urandom);
    e.resolve          = ($urandom % 3) == 0;
    e.select_target_pc = ($urandom % 2) == 0;
    e.squash_j         = ($urandom % 6) == 0;
    e.squash_jalr      = ($urandom % 7) == 0;
    return e;
  endfunction

  task automatic compare();
    chk("out_valid", o0_out_valid, q.size() != 0);
    chk("count", o0_count, q.size());
    chk("count_w2", o1_count, q.size());
    chk("shadow", o0_shadow, shadow_left > 0);
    chk("drop16", o0_drop, sat(drops, 65535));
    chk("drop2", o1_drop, sat(drops, 3));
    if (q.size() != 0) begin
      chk("rd", o0_rd, q[0].rd);
      chk("rs1", o0_rs1, q[0].rs1);
      chk("rs2", o0_rs2, q[0].rs2);
      chk("flags", {o0_res, o0_sel, o0_j, o0_jalr},
          {q[0].resolve, q[0].select_target_pc,
           q[0].squash_j, q[0].squash_jalr});
    end
  endtask

  // one cycle: drive at negedge, advance model, check after edge
  task automatic step(input logic iv,
                      input decode_entry_t e,
                      input logic ordy,
                      input logic fl,
                      output logic acc,
                      output logic rdy);
    logic pop;
    in_valid  = iv;
    in_rd     = e.rd;
    in_rs1    = e.rs1;
    in_rs2    = e.rs2;
    in_res    = e.resolve;
    in_sel    = e.select_target_pc;
    in_j      = e.squash_j;
    in_jalr   = e.squash_jalr;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy = o0_in_ready;
    chk("in_ready", o0_in_ready, (q.size() < DEPTH) && !fl);
    acc = iv && (q.size() < DEPTH) && !fl;
    pop = ordy && (q.size() > 0);
    if (fl) begin
      q.delete();
      shadow_left = 0;
    end else if (pop && q[0].resolve && q[0].select_target_pc) begin
      drops += q.size() - 1 + (acc ? 1 : 0);
      q.delete();
      shadow_left = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (shadow_left > 0) begin
          drops++;
          shadow_left--;
        end else begin
          q.push_back(e);
          if (e.squash_jalr && SJALR > 0) shadow_left = SJALR;
          else if (e.squash_j && SJ > 0) shadow_left = SJ;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    decode_entry_t z, e;
    logic acc, rdy;
    int d0, sh_cycles;
    bit got5;
    z = '0;
    flush = 0; in_valid = 0; out_ready = 0;
    {in_rd, in_rs1, in_rs2, in_res, in_sel, in_j, in_jalr} = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count", o0_count, 0);
    chk("rst_valid", o0_out_valid, 0);
    chk("rst_data", {o0_rd, o0_rs1, o0_rs2, o0_res, o0_sel,
                     o0_j, o0_jalr}, 0);
    chk("rst_shadow", o0_shadow, 0);
    chk("rst_drop", o0_drop, 0);
    chk("rst_in_ready", o0_in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare();

    // streaming with out_ready high
    for (int i = 0; i < 6; i++) begin
      step(1, mk(i + 1), 1, 0, acc, rdy);
      if (i == 0) begin
        chk("stream_first_valid", o0_out_valid, 1);
        chk("stream_first_rd", o0_rd, 1);
      end
      chk("stream_count", o0_count, 1);
    end
    step(0, z, 1, 0, acc, rdy);
    chk("stream_drop", o0_drop, 0);

    // fill to full, then drain
    for (int i = 0; i < 5; i++) step(1, mk(10 + i), 0, 0, acc, rdy);
    chk("full_count", o0_count, 4);
    chk("full_in_ready", o0_in_ready, 0);
    chk("full_head", o0_rd, 10);
    got5 = 0;
    for (int i = 0; i < 7; i++) begin
      step(!got5, mk(14), 1, 0, acc, rdy);
      if (acc) got5 = 1;
    end
    chk("fifth_accepted", got5, 1);

    // JALR shadow: two dropped, third written
    d0 = drops;
    sh_cycles = 0;
    e = mk(20);
    e.squash_jalr = 1;
    step(1, e, 1, 0, acc, rdy);
    sh_cycles += o0_shadow;
    e = mk(21);
    e.squash_j = 1;
    step(1, e, 1, 0, acc, rdy);
    sh_cycles += o0_shadow;
    step(1, mk(22), 1, 0, acc, rdy);
    sh_cycles += o0_shadow;
    step(1, mk(23), 0, 0, acc, rdy);
    sh_cycles += o0_shadow;
    chk("jalr_written_rd", o0_rd, 23);
    step(0, z, 1, 0, acc, rdy);
    sh_cycles += o0_shadow;
    chk("jalr_shadow_cycles", sh_cycles, 2);
    chk("jalr_drops", o0_drop - 16'(d0), 2);
    chk("model_jalr_drops", drops - d0, 2);
    step(0, z, 1, 0, acc, rdy);

    // redirect with three queued and a same-cycle accept
    d0 = drops;
    e = mk(30);
    e.resolve = 1;
    e.select_target_pc = 1;
    step(1, e, 0, 0, acc, rdy);
    step(1, mk(31), 0, 0, acc, rdy);
    step(1, mk(32), 0, 0, acc, rdy);
    chk("redir_pre_count", o0_count, 3);
    step(1, mk(33), 1, 0, acc, rdy);
    chk("redir_count", o0_count, 0);
    chk("redir_drops", o0_drop - 16'(d0), 3);

    // flush while shadowing with two queued
    step(1, mk(40), 0, 0, acc, rdy);
    e = mk(41);
    e.squash_j = 1;
    step(1, e, 0, 0, acc, rdy);
    chk("flush_pre_count", o0_count, 2);
    chk("flush_pre_shadow", o0_shadow, 1);
    d0 = o0_drop;
    step(1, mk(42), 0, 1, acc, rdy);
    chk("flush_in_ready", rdy, 0);
    chk("flush_count", o0_count, 0);
    chk("flush_shadow", o0_shadow, 0);
    chk("flush_drop", o0_drop, d0);

    // five drops so far: narrow counter saturates
    chk("drop16_total", o0_drop, 5);
    chk("drop2_sat", o1_drop, 3);

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 10) < 7, rnd_entry(),
           ($urandom % 10) < 6, ($urandom % 50) == 0,
           acc, rdy);
    end

    // async reset while full and shadowing
    step(0, z, 1, 1, acc, rdy);
    for (int i = 0; i < 3; i++) step(1, mk(50 + i), 0, 0, acc, rdy);
    e = mk(53);
    e.squash_jalr = 1;
    step(1, e, 0, 0, acc, rdy);
    chk("pre_rst_full", o0_count, 4);
    chk("pre_rst_shadow", o0_shadow, 1);
    in_valid = 0;
    flush = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", o0_count, 0);
    chk("arst_shadow", o0_shadow, 0);
    chk("arst_drop", o0_drop, 0);
    chk("arst_data", {o0_rd, o0_rs1, o0_rs2, o0_res, o0_sel,
                      o0_j, o0_jalr}, 0);
    q.delete();
    shadow_left = 0;
    drops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    compare();
    for (int i = 0; i < 3; i++) step(1, mk(60 + i), 1, 0, acc, rdy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
